pir_input_conditioner: RTL and testbench

//   Upstream front end of the PIR alarm controller. Synchronises the three raw PIR lines and

---
 rtl/pir_input_conditioner.sv | 191 +++++++++++++++++++
 tb/tb_pir_input_conditioner.sv | 241 ++++++++++++++++++++++++
 2 files changed

// File: rtl/pir_input_conditioner.sv
// rtl/pir_input_conditioner.sv - PIR input synchroniser, debouncer and retrigger holdoff
//
// Purpose:
//   Front end for the PIR alarm core. Each raw PIR line is synchronised (2 flops),
//   debounced in both directions and followed by a fixed retrigger holdoff after
//   every release. The per-channel clean level and a one-cycle rising pulse are
//   registered outputs. turn=0 forces every channel back to IDLE.
//   Optional macro FAULT_DETECT_EN adds a stuck-high detector (FAULT state).
//
// Ports:
//   clk           in   system clock, rising edge
//   reset         in   synchronous, active-high
//   turn          in   system arm; 0 holds all channels idle
//   pir_raw       in   [N_SENSORS] asynchronous raw sensor lines
//   pir_sensor    out  [N_SENSORS] clean level, 1 while channel is ACTIVE
//   motion_pulse  out  [N_SENSORS] one-cycle pulse on entry to ACTIVE
//   motion_any    out  registered OR of pir_sensor (one cycle behind it)
//   fault         out  [N_SENSORS] sticky stuck-high flag (0 without FAULT_DETECT_EN)

module pir_input_conditioner #(
  parameter int N_SENSORS       = 3,
  parameter int DEBOUNCE_CYCLES = 16,
  parameter int HOLDOFF_CYCLES  = 64,
  parameter int STUCK_CYCLES    = 4096,
  parameter int CNT_W           = 13
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 turn,
  input  logic [N_SENSORS-1:0] pir_raw,
  output logic [N_SENSORS-1:0] pir_sensor,
  output logic [N_SENSORS-1:0] motion_pulse,
  output logic                 motion_any,
  output logic [N_SENSORS-1:0] fault
);

`ifdef FAULT_DETECT_EN
  typedef enum logic [1:0] {ST_IDLE = 2'd0, ST_ACTIVE = 2'd1, ST_HOLDOFF = 2'd2, ST_FAULT = 2'd3} state_t;
  localparam logic [CNT_W-1:0] STUCK_LAST = CNT_W'(STUCK_CYCLES - 1);
`else
  typedef enum logic [1:0] {ST_IDLE = 2'd0, ST_ACTIVE = 2'd1, ST_HOLDOFF = 2'd2} state_t;
`endif

  localparam logic [CNT_W-1:0] DEB_LAST  = CNT_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'(HOLDOFF_CYCLES - 1);

  if (DEBOUNCE_CYCLES < 2 || HOLDOFF_CYCLES < 1 || STUCK_CYCLES < 1 || CNT_W > 30 ||
      (DEBOUNCE_CYCLES - 1) >= (1 << CNT_W) || (HOLDOFF_CYCLES - 1) >= (1 << CNT_W) ||
      (STUCK_CYCLES - 1) >= (1 << CNT_W)) begin : g_bad_params
    $error("pir_input_conditioner: parameter out of range");
  end

  // Counters hold at all-ones instead of wrapping.
  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (v == '1) ? v : v + 1'b1;
  endfunction

  logic [N_SENSORS-1:0] sync1_q, sync1_d, sync2_q, sync2_d;
  logic                 motion_any_q, motion_any_d;

  // The synchroniser is free-running; turn only gates the channel FSMs.
  always_comb begin
    sync1_d      = pir_raw;
    sync2_d      = sync1_q;
    motion_any_d = |pir_sensor;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      sync1_q      <= '0;
      sync2_q      <= '0;
      motion_any_q <= 1'b0;
    end else begin
      sync1_q      <= sync1_d;
      sync2_q      <= sync2_d;
      motion_any_q <= motion_any_d;
    end
  end

  assign motion_any = motion_any_q;

  for (genvar i = 0; i < N_SENSORS; i++) begin : g_ch
    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             sensor_q, sensor_d;
    logic             pulse_q, pulse_d;
    logic             s;
`ifdef FAULT_DETECT_EN
    logic [CNT_W-1:0] stk_q, stk_d;
    logic             fault_q, fault_d;
`endif

    assign s = sync2_q[i];

    always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
`ifdef FAULT_DETECT_EN
      stk_d   = stk_q;
`endif
      case (state_q)
        ST_IDLE: begin
          if (!s)                   cnt_d = '0;
          else if (cnt_q == DEB_LAST) begin
            state_d = ST_ACTIVE;
            cnt_d   = '0;
          end else                  cnt_d = sat_inc(cnt_q);
        end
        ST_ACTIVE: begin
          // cnt tracks the low run (release debounce); stk tracks the high run.
          if (s)                    cnt_d = '0;
          else if (cnt_q == DEB_LAST) begin
            state_d = ST_HOLDOFF;
            cnt_d   = '0;
          end else                  cnt_d = sat_inc(cnt_q);
`ifdef FAULT_DETECT_EN
          if (!s)                   stk_d = '0;
          else if (stk_q == STUCK_LAST) begin
            state_d = ST_FAULT;
            cnt_d   = '0;
          end else                  stk_d = sat_inc(stk_q);
`endif
        end
        ST_HOLDOFF: begin
          if (cnt_q == HOLD_LAST) begin
            state_d = ST_IDLE;
            cnt_d   = '0;
          end else                  cnt_d = sat_inc(cnt_q);
        end
`ifdef FAULT_DETECT_EN
        ST_FAULT: begin
          // Release from a stuck line skips the debounce and goes straight to holdoff.
          if (!s) begin
            state_d = ST_HOLDOFF;
            cnt_d   = '0;
          end
        end
`endif
        default: begin
          state_d = ST_IDLE;
          cnt_d   = '0;
        end
      endcase

      if (!turn) begin
        state_d = ST_IDLE;
        cnt_d   = '0;
      end

`ifdef FAULT_DETECT_EN
      // Every entry into ACTIVE starts a fresh stuck run.
      if (state_d != ST_ACTIVE) stk_d = '0;
      fault_d = turn && (fault_q || (state_d == ST_FAULT));
`endif
      // Outputs decode the next state so they change on the same edge as the FSM.
      sensor_d = (state_d == ST_ACTIVE);
      pulse_d  = (state_d == ST_ACTIVE) && (state_q != ST_ACTIVE);
    end

    always_ff @(posedge clk) begin
      if (reset) begin
        state_q  <= ST_IDLE;
        cnt_q    <= '0;
        sensor_q <= 1'b0;
        pulse_q  <= 1'b0;
`ifdef FAULT_DETECT_EN
        stk_q    <= '0;
        fault_q  <= 1'b0;
`endif
      end else begin
        state_q  <= state_d;
        cnt_q    <= cnt_d;
        sensor_q <= sensor_d;
        pulse_q  <= pulse_d;
`ifdef FAULT_DETECT_EN
        stk_q    <= stk_d;
        fault_q  <= fault_d;
`endif
      end
    end

    assign pir_sensor[i]   = sensor_q;
    assign motion_pulse[i] = pulse_q;
`ifdef FAULT_DETECT_EN
    assign fault[i]        = fault_q;
`else
    assign fault[i]        = 1'b0;
`endif
  end

endmodule

// File: tb/tb_pir_input_conditioner.sv
// tb/tb_pir_input_conditioner.sv - randomized and directed bench for pir_input_conditioner

module tb_pir_input_conditioner;

  localparam int N    = 3;
  localparam int D    = 4;
  localparam int H    = 8;
  localparam int S    = 32;
  localparam int MAXE = 4096;
`ifdef FAULT_DETECT_EN
  localparam bit FAULT_EN = 1'b1;
`else
  localparam bit FAULT_EN = 1'b0;
`endif

  localparam int M_IDLE = 0, M_ACTIVE = 1, M_HOLD = 2, M_FAULT = 3;

  logic         clk = 1'b0;
  logic         reset, turn;
  logic [N-1:0] pir_raw;
  logic [N-1:0] pir_sensor, motion_pulse, fault;
  logic         motion_any;

  pir_input_conditioner #(
    .N_SENSORS(N), .DEBOUNCE_CYCLES(D), .HOLDOFF_CYCLES(H), .STUCK_CYCLES(S), .CNT_W(6)
  ) dut (
    .clk(clk), .reset(reset), .turn(turn), .pir_raw(pir_raw),
    .pir_sensor(pir_sensor), .motion_pulse(motion_pulse),
    .motion_any(motion_any), .fault(fault)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int n = 0;

  logic [N-1:0] raw_hist [MAXE];
  logic         rst_hist [MAXE];

  int           mode  [N];
  int           entry [N];
  logic [N-1:0] exp_sensor, exp_pulse, exp_fault;
  logic         exp_any;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s edge %0d: got %0h expected %0h", tag, n, got, exp);
    end
  endtask

  // Level the FSM sees at edge m: raw sampled two edges earlier, zeroed by a reset in between.
  function automatic logic s_at(int ch, int m);
    if (m < 2) return 1'b0;
    if (rst_hist[m-1] || rst_hist[m-2]) return 1'b0;
    return raw_hist[m-2][ch];
  endfunction

  // True when the channel saw level v on every edge lo..hi, all after the phase entry edge.
  function automatic bit stable(int ch, int lo, int hi, logic v);
    if (lo <= entry[ch]) return 1'b0;
    for (int m = lo; m <= hi; m++)
      if (s_at(ch, m) !== v) return 1'b0;
    return 1'b1;
  endfunction

  task automatic model_edge(input logic rst, input logic t);
    if (rst) begin
      for (int c = 0; c < N; c++) begin
        mode[c]  = M_IDLE;
        entry[c] = n;
      end
      exp_sensor = '0; exp_pulse = '0; exp_fault = '0; exp_any = 1'b0;
      return;
    end
    exp_any = |exp_sensor;
    for (int c = 0; c < N; c++) begin
      exp_pulse[c] = 1'b0;
      if (!t) begin
        mode[c]      = M_IDLE;
        entry[c]     = n;
        exp_fault[c] = 1'b0;
      end else begin
        case (mode[c])
          M_IDLE:
            if (stable(c, n - D + 1, n, 1'b1)) begin
              mode[c] = M_ACTIVE; entry[c] = n; exp_pulse[c] = 1'b1;
            end
          M_ACTIVE:
            if (stable(c, n - D + 1, n, 1'b0)) begin
              mode[c] = M_HOLD; entry[c] = n;
            end else if (FAULT_EN && stable(c, n - S + 1, n, 1'b1)) begin
              mode[c] = M_FAULT; entry[c] = n; exp_fault[c] = 1'b1;
            end
          M_HOLD:
            if (n - entry[c] == H) begin
              mode[c] = M_IDLE; entry[c] = n;
            end
          default:
            if (s_at(c, n) == 1'b0) begin
              mode[c] = M_HOLD; entry[c] = n;
            end
        endcase
      end
      exp_sensor[c] = (mode[c] == M_ACTIVE);
    end
  endtask

  task automatic step(input logic rst, input logic t, input logic [N-1:0] raw);
    reset    = rst;
    turn     = t;
    pir_raw  = raw;
    rst_hist[n] = rst;
    raw_hist[n] = raw;
    @(posedge clk);
    #1;
    model_edge(rst, t);
    check_eq("pir_sensor", 32'(pir_sensor), 32'(exp_sensor));
    check_eq("motion_pulse", 32'(motion_pulse), 32'(exp_pulse));
    check_eq("motion_any", 32'(motion_any), 32'(exp_any));
    check_eq("fault", 32'(fault), 32'(exp_fault));
    n++;
  endtask

  task automatic go_idle();
    step(1'b0, 1'b0, '0);
    step(1'b0, 1'b0, '0);
    step(1'b0, 1'b0, '0);
    step(1'b0, 1'b1, '0);
  endtask

  initial begin
    int           k, first, pulses;
    logic [N-1:0] r;
    logic         t, rs;
    int           fp;

    reset = 1'b1; turn = 1'b0; pir_raw = '0;
    exp_sensor = '0; exp_pulse = '0; exp_fault = '0; exp_any = 1'b0;
    for (int c = 0; c < N; c++) begin mode[c] = M_IDLE; entry[c] = 0; end

    // Reset state
    for (int c = 0; c < 3; c++) step(1'b1, 1'b0, '0);
    check_eq("reset_outs", {pir_sensor, motion_pulse, fault, 1'b0, motion_any}, 32'd0);
    go_idle();

    // Clean rise: latency of DEBOUNCE+1 edges and a single pulse
    k = n; first = -1; pulses = 0;
    for (int c = 0; c < 12; c++) begin
      step(1'b0, 1'b1, 3'b001);
      if (first < 0 && pir_sensor[0]) first = n - 1 - k;
      if (motion_pulse[0]) pulses++;
    end
    check_eq("t1_latency", first, 5);
    check_eq("t1_pulses", pulses, 1);
    go_idle();
    for (int c = 0; c < 20; c++) step(1'b0, 1'b1, '0);

    // Glitch on channel 1: 3 high, 1 low, then held high
    for (int c = 0; c < 3; c++) step(1'b0, 1'b1, 3'b010);
    step(1'b0, 1'b1, 3'b000);
    k = n; first = -1;
    for (int c = 0; c < 12; c++) begin
      step(1'b0, 1'b1, 3'b010);
      if (first < 0 && pir_sensor[1]) first = n - 1 - k;
    end
    check_eq("t2_latency", first, 5);
    go_idle();
    for (int c = 0; c < 20; c++) step(1'b0, 1'b1, '0);

    // Holdoff on channel 2: re-rise during holdoff must requalify afterwards
    pulses = 0;
    for (int c = 0; c < 8; c++) begin step(1'b0, 1'b1, 3'b100); if (motion_pulse[2]) pulses++; end
    for (int c = 0; c < 6; c++) begin step(1'b0, 1'b1, 3'b000); if (motion_pulse[2]) pulses++; end
    k = n; first = -1;
    for (int c = 0; c < 25; c++) begin
      step(1'b0, 1'b1, 3'b100);
      if (motion_pulse[2]) begin pulses++; if (first < 0) first = n - 1 - k; end
    end
    check_eq("t3_pulses", pulses, 2);
    check_eq("t3_repulse_edge", first, 11);

    // turn=0 mid-ACTIVE with all channels high, then re-arm
    for (int c = 0; c < 10; c++) step(1'b0, 1'b1, 3'b111);
    step(1'b0, 1'b0, 3'b111);
    check_eq("t4_turn_off", 32'(pir_sensor), 32'd0);
    k = n; first = -1;
    for (int c = 0; c < 10; c++) begin
      step(1'b0, 1'b1, 3'b111);
      if (first < 0 && pir_sensor == 3'b111) first = n - 1 - k;
    end
    check_eq("t4_rearm_latency", first, 3);

    // Simultaneous rise
    go_idle();
    for (int c = 0; c < 20; c++) step(1'b0, 1'b1, '0);
    pulses = 0;
    for (int c = 0; c < 10; c++) begin step(1'b0, 1'b1, 3'b111); if (motion_pulse == 3'b111) pulses++; end
    check_eq("t5_all_pulse", pulses, 1);
    check_eq("t5_all_sensor", 32'(pir_sensor), 32'h7);

    // Mid-operation reset
    step(1'b1, 1'b1, 3'b111);
    check_eq("reset_mid", {pir_sensor, motion_pulse, fault, 1'b0, motion_any}, 32'd0);
    go_idle();
    for (int c = 0; c < 20; c++) step(1'b0, 1'b1, '0);

    // Long high on channel 0
    for (int c = 0; c < 40; c++) step(1'b0, 1'b1, 3'b001);
`ifdef FAULT_DETECT_EN
    check_eq("t6_fault", 32'(fault[0]), 32'd1);
    check_eq("t6_sensor", 32'(pir_sensor[0]), 32'd0);
`else
    check_eq("t6_fault", 32'(fault), 32'd0);
    check_eq("t6_sensor", 32'(pir_sensor[0]), 32'd1);
`endif
    for (int c = 0; c < 20; c++) step(1'b0, 1'b1, 3'b000);
    step(1'b0, 1'b0, 3'b000);
    check_eq("t6_fault_clear", 32'(fault), 32'd0);

    // Randomized traffic alternating slow and glitchy phases
    r = '0; t = 1'b1;
    for (int c = 0; c < 2500; c++) begin
      fp = ((c / 250) % 2 == 1) ? 2 : 12;
      for (int b = 0; b < N; b++)
        if ($urandom_range(0, fp - 1) == 0) r[b] = ~r[b];
      if (t) begin
        if ($urandom_range(0, 99) == 0) t = 1'b0;
      end else if ($urandom_range(0, 2) == 0) t = 1'b1;
      if (c % 500 == 300) r = '1;
      rs = ($urandom_range(0, 599) == 0);
      step(rs, t, r);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
